// File: rtl/c17_resp_checker.sv
// ----------------------------------------------------------------------------
// c17_resp_checker
//
// Purpose:
//   On-chip response checker for the exhaustive c17 test flow. Each vector
//   applied to the pipelined c17 is also presented here. The golden N22/N23
//   response is computed combinationally and carried down per-output delay
//   lines matching the DUT pipeline latency. When the delayed entry arrives it
//   is compared against the registered DUT output. Mismatches are counted with
//   saturation and the sequence index of the first failing vector is latched.
//
// Optional feature (macro C17CHK_SPLIT_CNT_EN):
//   When defined, separate saturating mismatch counters for N22 and N23 are
//   exposed on err22_count / err23_count. When undefined those ports do not
//   exist.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   start            begin a run (honoured in IDLE or DONE only)
//   vec_valid        vec is being applied to the DUT this cycle
//   vec[4:0]         {N7,N6,N3,N2,N1}, bit0 = N1
//   dut_n22/dut_n23  registered c17 DUT outputs
//   busy             state is RUN or DRAIN
//   done             run complete, held until next start or rst
//   pass             done and err_count == 0
//   err_count        total mismatches, saturating
//   first_fail_valid at least one mismatch seen in this run
//   first_fail_idx   0-based sequence number of the first failing vector
//   err22_count      N22 mismatches (C17CHK_SPLIT_CNT_EN only)
//   err23_count      N23 mismatches (C17CHK_SPLIT_CNT_EN only)
//   dbg_state        current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Handshake: there is no back-pressure. A vector is accepted on every rising
// edge where vec_valid is 1 and the FSM is in RUN; vec_valid in any other
// state is ignored.
// ----------------------------------------------------------------------------
module c17_resp_checker #(
  parameter int NUM_VECTORS = 32,
  parameter int LAT22       = 2,
  parameter int LAT23       = 3,
  parameter int ERRW        = 8,
  localparam int IDXW       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            vec_valid,
  input  logic [4:0]      vec,
  input  logic            dut_n22,
  input  logic            dut_n23,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic            first_fail_valid,
  output logic [IDXW-1:0] first_fail_idx,
`ifdef C17CHK_SPLIT_CNT_EN
  output logic [ERRW-1:0] err22_count,
  output logic [ERRW-1:0] err23_count,
`endif
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAXLAT = (LAT22 > LAT23) ? LAT22 : LAT23;
  localparam int DRW    = $clog2(MAXLAT + 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] vec_cnt;
  logic [DRW-1:0]  drain_cnt;

  // Delay lines: valid, expected value and sequence index per stage.
  logic [LAT22-1:0] v22_q, e22_q;
  logic [LAT23-1:0] v23_q, e23_q;
  logic [IDXW-1:0]  i22_q [LAT22];
  logic [IDXW-1:0]  i23_q [LAT23];

  logic accept, run_start, last_accept;
  logic g22, g23;
  logic n10, n11, n16, n19;
  logic miss22, miss23, any_miss;
  logic [IDXW-1:0] ff_idx_d;
  logic [ERRW-1:0] err_next;

  // Saturating add of a 0..2 increment.
  function automatic logic [ERRW-1:0] sat_add(input logic [ERRW-1:0] a,
                                               input logic [1:0]      inc);
    logic [ERRW:0] s;
    s = {1'b0, a} + (ERRW+1)'(inc);
    return s[ERRW] ? {ERRW{1'b1}} : s[ERRW-1:0];
  endfunction

  // Golden c17 netlist.
  always_comb begin
    n10 = ~(vec[0] & vec[2]);
    n11 = ~(vec[2] & vec[3]);
    n16 = ~(vec[1] & n11);
    n19 = ~(n11 & vec[4]);
    g22 = ~(n10 & n16);
    g23 = ~(n16 & n19);
  end

  assign accept      = vec_valid && (state_q == RUN);
  assign run_start   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_accept = (vec_cnt == IDXW'(NUM_VECTORS - 1));

  assign miss22   = v22_q[LAT22-1] && (dut_n22 != e22_q[LAT22-1]);
  assign miss23   = v23_q[LAT23-1] && (dut_n23 != e23_q[LAT23-1]);
  assign any_miss = miss22 || miss23;
  assign err_next = sat_add(err_count, {1'b0, miss22} + {1'b0, miss23});

  // When both outputs fail in the same cycle they belong to different
  // vectors; the earlier vector (smaller index) is the one reported.
  always_comb begin
    ff_idx_d = i23_q[LAT23-1];
    if (miss22 && miss23) begin
      ff_idx_d = (i22_q[LAT22-1] < i23_q[LAT23-1]) ? i22_q[LAT22-1]
                                                   : i23_q[LAT23-1];
    end else if (miss22) begin
      ff_idx_d = i22_q[LAT22-1];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_accept) state_d = DRAIN;
      DRAIN:   if (drain_cnt == DRW'(MAXLAT - 1)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      vec_cnt          <= '0;
      drain_cnt        <= '0;
      v22_q            <= '0;
      e22_q            <= '0;
      v23_q            <= '0;
      e23_q            <= '0;
      for (int i = 0; i < LAT22; i++) i22_q[i] <= '0;
      for (int i = 0; i < LAT23; i++) i23_q[i] <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
`ifdef C17CHK_SPLIT_CNT_EN
      err22_count      <= '0;
      err23_count      <= '0;
`endif
    end else begin
      state_q <= state_d;

      // Delay lines shift every cycle; bubbles carry valid = 0.
      v22_q[0] <= accept;
      e22_q[0] <= g22;
      i22_q[0] <= vec_cnt;
      for (int i = 1; i < LAT22; i++) begin
        v22_q[i] <= v22_q[i-1];
        e22_q[i] <= e22_q[i-1];
        i22_q[i] <= i22_q[i-1];
      end
      v23_q[0] <= accept;
      e23_q[0] <= g23;
      i23_q[0] <= vec_cnt;
      for (int i = 1; i < LAT23; i++) begin
        v23_q[i] <= v23_q[i-1];
        e23_q[i] <= e23_q[i-1];
        i23_q[i] <= i23_q[i-1];
      end

      if (state_q == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                  drain_cnt <= '0;

      if (run_start) begin
        vec_cnt          <= '0;
        err_count        <= '0;
        first_fail_valid <= 1'b0;
        first_fail_idx   <= '0;
`ifdef C17CHK_SPLIT_CNT_EN
        err22_count      <= '0;
        err23_count      <= '0;
`endif
      end else begin
        if (accept) vec_cnt <= vec_cnt + 1'b1;
        err_count <= err_next;
        if (any_miss && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_idx   <= ff_idx_d;
        end
`ifdef C17CHK_SPLIT_CNT_EN
        err22_count <= sat_add(err22_count, {1'b0, miss22});
        err23_count <= sat_add(err23_count, {1'b0, miss23});
`endif
      end
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_count == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_c17_resp_checker.sv
// ----------------------------------------------------------------------------
// tb_c17_resp_checker
//
// Drives the checker with exhaustive c17 runs against a behavioural
// pipelined c17 (N22 latency 2, N23 latency 3) that can be faulted: N22
// stuck-at-0, N23 stuck-at-1, both inverted, or N23 delayed one extra cycle.
// A second checker instance with ERRW=4 shares the stimulus to exercise
// counter saturation. Expected run results are pushed to exp_q as vectors are
// driven and popped when the checker reports done.
// ----------------------------------------------------------------------------
module tb_c17_resp_checker;

  localparam int W = 35;  // {pass, ffv, ffi[4:0], e8[7:0], e4[3:0], e22[7:0], e23[7:0]}

  logic       clk = 1'b0;
  logic       rst, start, vec_valid;
  logic [4:0] vec;
  logic       dut_n22, dut_n23;

  logic       busy, done, pass, first_fail_valid;
  logic [7:0] err_count;
  logic [4:0] first_fail_idx;
  logic [1:0] dbg_state;

  logic       busy4, done4, pass4, ffv4;
  logic [3:0] err_count4;
  logic [4:0] ffi4;
  logic [1:0] dbg_state4;
`ifdef C17CHK_SPLIT_CNT_EN
  logic [7:0] err22_count, err23_count;
  logic [3:0] err22_count4, err23_count4;
`endif

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int mode   = 0;

  c17_resp_checker #(.NUM_VECTORS(32), .LAT22(2), .LAT23(3), .ERRW(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_n22(dut_n22), .dut_n23(dut_n23),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
`ifdef C17CHK_SPLIT_CNT_EN
    .err22_count(err22_count), .err23_count(err23_count),
`endif
    .dbg_state(dbg_state)
  );

  c17_resp_checker #(.NUM_VECTORS(32), .LAT22(2), .LAT23(3), .ERRW(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_n22(dut_n22), .dut_n23(dut_n23),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err_count4),
    .first_fail_valid(ffv4), .first_fail_idx(ffi4),
`ifdef C17CHK_SPLIT_CNT_EN
    .err22_count(err22_count4), .err23_count(err23_count4),
`endif
    .dbg_state(dbg_state4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  // ---------------- reference c17 and faultable pipelined DUT ----------------
  // Sum-of-products form: N22 = N1N3 + N2(N3N6)', N23 = (N3N6)'(N2 + N7).
  function automatic logic [1:0] c17_ref(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, nand36;
    n1 = v[0]; n2 = v[1]; n3 = v[2]; n6 = v[3]; n7 = v[4];
    nand36 = ~(n3 & n6);
    return {nand36 & (n2 | n7), (n1 & n3) | (n2 & nand36)};
  endfunction

  logic [1:0] p22 = '0;
  logic [3:0] p23 = '0;
  logic [1:0] ref_now;
  assign ref_now = c17_ref(vec);

  always @(posedge clk) begin
    p22 <= {p22[0], ref_now[0]};
    p23 <= {p23[2:0], ref_now[1]};
  end

  always_comb begin
    dut_n22 = p22[1];
    dut_n23 = p23[2];
    case (mode)
      1: dut_n22 = 1'b0;
      2: dut_n23 = 1'b1;
      3: begin dut_n22 = ~p22[1]; dut_n23 = ~p23[2]; end
      4: dut_n23 = p23[3];
      default: ;
    endcase
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Full run of 32 ascending vectors in fault mode m with 'gap' idle cycles
  // after each vector. Expected results are modelled while driving.
  task automatic run_vectors(input int m, input int gap, input bit start_mid,
                             output int lat);
    logic [1:0] r;
    logic f22, f23, mm22, mm23, ffv;
    int e8, e4, e22c, e23c, ffi, cyc;
    e8 = 0; e4 = 0; e22c = 0; e23c = 0; ffv = 1'b0; ffi = 0;
    mode = m;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 32; i++) begin
      vec_valid = 1'b1;
      vec = i[4:0];
      if (start_mid && i == 5) start = 1'b1;
      r = c17_ref(vec);
      f22 = (m == 1) ? 1'b0 : (m == 3) ? ~r[0] : r[0];
      f23 = (m == 2) ? 1'b1 : (m == 3) ? ~r[1] : r[1];
      mm22 = (f22 != r[0]);
      mm23 = (f23 != r[1]);
      e22c += int'(mm22);
      e23c += int'(mm23);
      e8 = e8 + int'(mm22) + int'(mm23); if (e8 > 255) e8 = 255;
      e4 = e4 + int'(mm22) + int'(mm23); if (e4 > 15)  e4 = 15;
      if (!ffv && (mm22 || mm23)) begin ffv = 1'b1; ffi = i; end
      @(negedge clk);
      start = 1'b0;
      vec_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    if (m != 4)
      exp_q.push_back({(e8 == 0), ffv, ffi[4:0], e8[7:0], e4[3:0], e22c[7:0], e23c[7:0]});
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    lat = cyc;
  endtask

  task automatic compare_run(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pass"},     32'(pass),             32'(e[34]));
      check({tag, "_ffv"},      32'(first_fail_valid), 32'(e[33]));
      if (e[33]) check({tag, "_ffi"}, 32'(first_fail_idx), 32'(e[32:28]));
      check({tag, "_err"},      32'(err_count),        32'(e[27:20]));
      check({tag, "_err4"},     32'(err_count4),       32'(e[19:16]));
`ifdef C17CHK_SPLIT_CNT_EN
      check({tag, "_err22"},    32'(err22_count),      32'(e[15:8]));
      check({tag, "_err23"},    32'(err23_count),      32'(e[7:0]));
`endif
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy),             32'd0);
    check("rst_done",  32'(done),             32'd0);
    check("rst_pass",  32'(pass),             32'd0);
    check("rst_err",   32'(err_count),        32'd0);
    check("rst_ffv",   32'(first_fail_valid), 32'd0);
    check("rst_ffi",   32'(first_fail_idx),   32'd0);
    check("rst_state", 32'(dbg_state),        32'd0);
    rst = 1'b0;

    // vec_valid in IDLE must not start anything.
    vec_valid = 1'b1;
    repeat (4) @(negedge clk);
    vec_valid = 1'b0;
    check("idle_ignore_state", 32'(dbg_state), 32'd0);

    // Golden run, one vector per cycle.
    run_vectors(0, 0, 1'b0, lat);
    check("golden_latency", 32'(lat >= 3 && lat <= 4), 32'd1);
    check("golden_pass_const", 32'(pass),      32'd1);
    check("golden_err_const",  32'(err_count), 32'd0);
    compare_run("golden");

    // done holds; vec_valid in DONE is ignored even with a faulty DUT.
    mode = 1;
    vec_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin vec = 5'(i + 2); @(negedge clk); end
    vec_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("done_hold",         32'(done),      32'd1);
    check("done_ignore_err",   32'(err_count), 32'd0);

    run_vectors(1, 0, 1'b0, lat);
    check("n22sa0_err_const", 32'(err_count),      32'd18);
    check("n22sa0_ffi_const", 32'(first_fail_idx), 32'd2);
    check("n22sa0_pass",      32'(pass),           32'd0);
    compare_run("n22sa0");

    run_vectors(2, 0, 1'b0, lat);
    check("n23sa1_err_const", 32'(err_count),      32'd14);
    check("n23sa1_ffi_const", 32'(first_fail_idx), 32'd0);
    compare_run("n23sa1");

    run_vectors(3, 0, 1'b0, lat);
    check("inv_err4_sat",     32'(err_count4), 32'd15);
    check("inv_ffi4",         32'(ffi4),       32'd0);
    check("inv_err8",         32'(err_count),  32'd64);
    compare_run("inverted");

    run_vectors(4, 0, 1'b0, lat);
    check("n23late_err_nonzero", 32'(err_count != 0), 32'd1);
    check("n23late_pass",        32'(pass),           32'd0);

    run_vectors(0, 3, 1'b0, lat);
    check("gaps_pass_const", 32'(pass), 32'd1);
    compare_run("gaps");

    // Reset in the middle of a faulty run.
    mode = 1;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      vec_valid = 1'b1; vec = i[4:0];
      @(negedge clk);
    end
    check("midrun_busy",        32'(busy),           32'd1);
    check("midrun_err_nonzero", 32'(err_count != 0), 32'd1);
    vec = 5'd10; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; vec_valid = 1'b0;
    check("midrst_state", 32'(dbg_state),        32'd0);
    check("midrst_busy",  32'(busy),             32'd0);
    check("midrst_done",  32'(done),             32'd0);
    check("midrst_err",   32'(err_count),        32'd0);
    check("midrst_ffv",   32'(first_fail_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(done), 32'd0);

    // Golden run with a stray start at vector 5 (must be ignored).
    run_vectors(0, 0, 1'b1, lat);
    check("after_rst_pass", 32'(pass), 32'd1);
    compare_run("after_rst");

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
